// File: rtl/sdrxframe_pkg.sv
// sdrxframe_pkg: shared definitions for the SD receive data framer.
//   state_e    - framer FSM states
//   status_e   - completion status codes reported on o_status
//   CRC16_POLY - CRC16-CCITT polynomial used on every DAT lane
package sdrxframe_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_DATA,
    S_CRC,
    S_STOP,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    STAT_OK       = 2'b00,
    STAT_CRCERR   = 2'b01,
    STAT_TIMEOUT  = 2'b10,
    STAT_OVERFLOW = 2'b11
  } status_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

endpackage

// File: rtl/sdrxframe_crc.sv
// sdrxcrc16: single-lane serial CRC16 (x^16+x^12+x^5+1), initial value 0.
//   i_clk, i_reset : system clock, synchronous active-high reset
//   clear_i        : reset the running CRC to zero (wins over en_i)
//   en_i           : fold bit_i into the CRC this cycle
//   bit_i          : serial data bit, MSB first
//   crc_o          : current CRC value
module sdrxcrc16
  import sdrxframe_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    crc_d = crc_q;
    fb    = bit_i ^ crc_q[15];
    if (clear_i)
      crc_d = '0;
    else if (en_i)
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      crc_q <= '0;
    else
      crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sdrxframe.sv
// sdrxframe: SD card receive data framer.
// Waits for a start bit on the active DAT lanes, deserialises one block
// (1-bit or 4-bit bus) MSB first into bytes, checks per-lane CRC16 and the
// end bit, and writes bytes into a downstream FIFO.
//   i_clk, i_reset : system clock, synchronous active-high reset
//   i_en           : arm for one block (ignored while busy)
//   i_abort        : return to idle without o_done
//   i_width        : 0 = 1-bit bus, 1 = 4-bit bus (sampled at i_en)
//   i_lgblk        : log2 block length in bytes (sampled at i_en)
//   i_ce, i_dat    : per-SD-clock sample strobe and DAT lines
//   i_full         : downstream FIFO full
//   o_wr, o_data   : FIFO byte write
//   o_busy, o_done : frame in progress / one-cycle completion pulse
//   o_status       : 00 ok, 01 CRC/end-bit error, 10 timeout, 11 overflow
module sdrxframe
  import sdrxframe_pkg::*;
#(
  parameter int unsigned OPT_4BIT  = 1,
  parameter int unsigned LGMAXBLK  = 9,
  parameter int unsigned LGTIMEOUT = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_abort,
  input  logic       i_width,
  input  logic [3:0] i_lgblk,
  input  logic       i_ce,
  input  logic [3:0] i_dat,
  input  logic       i_full,
  output logic       o_wr,
  output logic [7:0] o_data,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_status
);

  // Timeout fires on the strobe that would take the counter to all-ones.
  localparam logic [LGTIMEOUT-1:0] TO_LAST = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

  state_e                 state_q,   state_d;
  status_e                status_q,  status_d;
  logic                   width_q,   width_d;
  logic [3:0]             lgblk_q,   lgblk_d;
  logic [LGTIMEOUT-1:0]   tocnt_q,   tocnt_d;
  logic [2:0]             bitcnt_q,  bitcnt_d;
  logic [LGMAXBLK:0]      bytecnt_q, bytecnt_d;
  logic [3:0]             crccnt_q,  crccnt_d;
  logic [7:0]             sreg_q,    sreg_d;
  logic [7:0]             pend_q,    pend_d;
  logic                   wrpend_q,  wrpend_d;
  logic [7:0]             out_q,     out_d;
  logic                   ovf_q,     ovf_d;
  logic                   err_q,     err_d;

  logic                   crc_clr;
  logic [3:0]             crc_en;
  logic [15:0]            lane_crc [4];

  logic [3:0]             lanes;
  logic [2:0]             bit_last;
  logic [LGMAXBLK:0]      blklen;
  logic [LGMAXBLK:0]      bytecnt_inc;
  logic [3:0]             crcbit;
  logic                   start_bit;
  logic                   stop_err;
  logic                   crc_bad;

  // width_q is forced to 0 when OPT_4BIT=0, which keeps lanes 1-3 disabled
  // everywhere (start/stop detection, CRC enables and CRC comparison).
  assign lanes       = width_q ? 4'hF : 4'h1;
  assign bit_last    = width_q ? 3'd1 : 3'd7;
  assign blklen      = {{LGMAXBLK{1'b0}}, 1'b1} << lgblk_q;
  assign bytecnt_inc = bytecnt_q + 1'b1;
  assign crcbit      = 4'd15 - crccnt_q;
  assign start_bit   = ((i_dat & lanes) == 4'h0);
  assign stop_err    = ((i_dat & lanes) != lanes);

  always_comb begin
    crc_bad = 1'b0;
    for (int unsigned l = 0; l < 4; l++)
      if (lanes[l] && (i_dat[l] != lane_crc[l][crcbit]))
        crc_bad = 1'b1;
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    sdrxcrc16 u_crc (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .clear_i (crc_clr),
      .en_i    (crc_en[l]),
      .bit_i   (i_dat[l]),
      .crc_o   (lane_crc[l])
    );
  end

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    width_d   = width_q;
    lgblk_d   = lgblk_q;
    tocnt_d   = tocnt_q;
    bitcnt_d  = bitcnt_q;
    bytecnt_d = bytecnt_q;
    crccnt_d  = crccnt_q;
    sreg_d    = sreg_q;
    pend_d    = pend_q;
    wrpend_d  = wrpend_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    crc_clr   = 1'b0;
    crc_en    = 4'h0;

    // A completed byte is offered to the FIFO the cycle after its strobe;
    // if the FIFO is full at that moment the byte is dropped.
    if (wrpend_q) begin
      wrpend_d = 1'b0;
      if (i_full)
        ovf_d = 1'b1;
      else
        out_d = pend_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_en) begin
          width_d   = (OPT_4BIT != 0) && i_width;
          lgblk_d   = i_lgblk;
          tocnt_d   = '0;
          bitcnt_d  = '0;
          bytecnt_d = '0;
          crccnt_d  = '0;
          ovf_d     = 1'b0;
          err_d     = 1'b0;
          crc_clr   = 1'b1;
          state_d   = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (i_ce) begin
          if (start_bit) begin
            state_d = S_DATA;
          end else if (tocnt_q == TO_LAST) begin
            state_d  = S_DONE;
            status_d = STAT_TIMEOUT;
          end else begin
            tocnt_d = tocnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (i_ce) begin
          crc_en = lanes;
          sreg_d = width_q ? {sreg_q[3:0], i_dat} : {sreg_q[6:0], i_dat[0]};
          if (bitcnt_q == bit_last) begin
            bitcnt_d  = '0;
            pend_d    = sreg_d;
            wrpend_d  = 1'b1;
            bytecnt_d = bytecnt_inc;
            if (bytecnt_inc == blklen)
              state_d = S_CRC;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      S_CRC: begin
        if (i_ce) begin
          if (crc_bad)
            err_d = 1'b1;
          crccnt_d = crccnt_q + 1'b1;
          if (crccnt_q == 4'd15)
            state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (i_ce) begin
          err_d   = err_q | stop_err;
          state_d = S_DONE;
          if (ovf_d)
            status_d = STAT_OVERFLOW;
          else if (err_d)
            status_d = STAT_CRCERR;
          else
            status_d = STAT_OK;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (i_abort) begin
      state_d  = S_IDLE;
      wrpend_d = 1'b0;
      status_d = status_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      status_q  <= STAT_OK;
      width_q   <= 1'b0;
      lgblk_q   <= '0;
      tocnt_q   <= '0;
      bitcnt_q  <= '0;
      bytecnt_q <= '0;
      crccnt_q  <= '0;
      sreg_q    <= '0;
      pend_q    <= '0;
      wrpend_q  <= 1'b0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      width_q   <= width_d;
      lgblk_q   <= lgblk_d;
      tocnt_q   <= tocnt_d;
      bitcnt_q  <= bitcnt_d;
      bytecnt_q <= bytecnt_d;
      crccnt_q  <= crccnt_d;
      sreg_q    <= sreg_d;
      pend_q    <= pend_d;
      wrpend_q  <= wrpend_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign o_wr     = wrpend_q && !i_full;
  // o_data shows the pending byte only while it is actually written, so a
  // dropped byte never disturbs the last value handed to the FIFO.
  assign o_data   = o_wr ? pend_q : out_q;
  assign o_busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done   = (state_q == S_DONE);
  assign o_status = status_q;

endmodule

// File: tb/tb_sdrxframe.sv
// tb_sdrxframe: directed self-checking bench for sdrxframe.
module tb_sdrxframe;

  logic       clk = 1'b0;
  logic       i_reset, i_en, i_abort, i_width, i_ce, i_full;
  logic [3:0] i_lgblk, i_dat;
  logic       o_wr, o_busy, o_done;
  logic [7:0] o_data;
  logic [1:0] o_status;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdrxframe #(.OPT_4BIT(1), .LGMAXBLK(9), .LGTIMEOUT(4)) dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
    .i_en     (i_en),
    .i_abort  (i_abort),
    .i_width  (i_width),
    .i_lgblk  (i_lgblk),
    .i_ce     (i_ce),
    .i_dat    (i_dat),
    .i_full   (i_full),
    .o_wr     (o_wr),
    .o_data   (o_data),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_status (o_status)
  );

  // Output monitor, sampled on the falling edge.
  logic [7:0] wq [$];
  int         wcyc [$];
  int         cyc = 0;
  int         done_cnt = 0;
  logic [1:0] last_status = 2'b00;

  always @(negedge clk) begin
    cyc++;
    if (o_wr) begin
      wq.push_back(o_data);
      wcyc.push_back(cyc);
    end
    if (o_done) begin
      done_cnt++;
      last_status = o_status;
    end
  end

  logic [7:0] tx [512];
  int         gap     = 1;
  int         full_at = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic [16:0] t;
    t = {c, 1'b0};
    if (t[16] ^ b) t[15:0] = t[15:0] ^ 16'h1021;
    return t[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] d, input logic fl);
    i_ce   = 1'b1;
    i_dat  = d;
    i_full = fl;
    tick();
    i_ce   = 1'b0;
    i_full = 1'b0;
    i_dat  = 4'hF;
    for (int k = 1; k < gap; k++) tick();
  endtask

  // Sends one frame; inactive lanes are driven 0 to prove they are ignored.
  // stop_at >= 0 returns after that many data strobes (for abort/reset tests).
  task automatic send_frame(input logic w, input int lg, input int stop_at,
                            input int flip_lane, input int flip_bit, input logic [3:0] endv);
    logic [15:0] lc [4];
    logic [3:0]  act, d;
    logic [7:0]  b;
    int          nb, ds;
    act = w ? 4'hF : 4'h1;
    for (int l = 0; l < 4; l++) lc[l] = 16'h0000;
    nb = 1 << lg;
    i_en = 1'b1; i_width = w; i_lgblk = lg[3:0];
    tick();
    i_en = 1'b0;
    strobe(act, 1'b0);
    strobe(act, 1'b0);
    strobe(4'h0, 1'b0);
    ds = 0;
    for (int i = 0; i < nb; i++) begin
      b = tx[i];
      for (int s = 0; s < (w ? 2 : 8); s++) begin
        if (stop_at >= 0 && ds == stop_at) return;
        if (w) d = (s == 0) ? b[7:4] : b[3:0];
        else   d = {3'b000, b[7-s]};
        for (int l = 0; l < 4; l++)
          if (act[l]) lc[l] = crc_step(lc[l], d[l]);
        strobe(d, ds == full_at);
        ds++;
      end
    end
    for (int i = 0; i < 16; i++) begin
      d = 4'h0;
      for (int l = 0; l < 4; l++)
        if (act[l]) d[l] = lc[l][15-i] ^ ((l == flip_lane) && (i == flip_bit));
      strobe(d, 1'b0);
    end
    strobe(endv & act, 1'b0);
  endtask

  task automatic wait_done(input string tag, input int d0);
    for (int i = 0; i < 50 && done_cnt == d0; i++) tick();
    check({tag, "_done"}, done_cnt - d0, 1);
    tick();
  endtask

  task automatic clear_mon();
    wq.delete();
    wcyc.delete();
  endtask

  task automatic verify_bytes(input string tag, input int n);
    int bad;
    bad = 0;
    check({tag, "_count"}, wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++)
      if (wq[i] !== tx[i]) bad++;
    check({tag, "_order"}, bad, 0);
  endtask

  task automatic load_small();
    tx[0] = 8'hA5; tx[1] = 8'h3C; tx[2] = 8'h00; tx[3] = 8'hFF;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 512; i++) tx[i] = i[7:0];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    i_reset = 1'b1; i_en = 1'b0; i_abort = 1'b0; i_width = 1'b0;
    i_lgblk = 4'd2; i_ce = 1'b0; i_dat = 4'hF; i_full = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_wr", o_wr, 0);
    check("rst_data", o_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_status", o_status, 0);
    tick();
    i_reset = 1'b0;
    tick();

    // 1-bit, 4 bytes, strobe every cycle
    load_small(); clear_mon(); gap = 1; d0 = done_cnt;
    send_frame(1'b0, 2, -1, -1, -1, 4'hF);
    wait_done("b1", d0);
    verify_bytes("b1", 4);
    check("b1_status", last_status, 2'b00);
    check("b1_spacing", (wcyc.size() > 1) ? wcyc[1] - wcyc[0] : 0, 8);
    check("b1_hold", o_data, 8'hFF);
    check("b1_busy", o_busy, 0);

    // 4-bit, 4 bytes, strobe every cycle
    clear_mon(); d0 = done_cnt;
    send_frame(1'b1, 2, -1, -1, -1, 4'hF);
    wait_done("n1", d0);
    verify_bytes("n1", 4);
    check("n1_status", last_status, 2'b00);
    check("n1_spacing", (wcyc.size() > 1) ? wcyc[1] - wcyc[0] : 0, 2);

    // 4-bit, 512 bytes, strobe every 3rd cycle
    load_ramp(); clear_mon(); gap = 3; d0 = done_cnt;
    send_frame(1'b1, 9, -1, -1, -1, 4'hF);
    wait_done("big", d0);
    verify_bytes("big", 512);
    check("big_status", last_status, 2'b00);
    check("big_spacing", (wcyc.size() > 1) ? wcyc[1] - wcyc[0] : 0, 6);
    check("big_busy", o_busy, 0);

    // CRC bit flipped on lane 2
    clear_mon(); d0 = done_cnt;
    send_frame(1'b1, 9, -1, 2, 5, 4'hF);
    wait_done("crc", d0);
    verify_bytes("crc", 512);
    check("crc_status", last_status, 2'b01);

    // end bit 0 on lane 3
    clear_mon(); d0 = done_cnt;
    send_frame(1'b1, 9, -1, -1, -1, 4'h7);
    wait_done("end", d0);
    verify_bytes("end", 512);
    check("end_status", last_status, 2'b01);

    // overflow: FIFO full in the 3rd byte's write cycle
    load_small(); clear_mon(); gap = 1; full_at = 24; d0 = done_cnt;
    send_frame(1'b0, 2, -1, -1, -1, 4'hF);
    full_at = -1;
    wait_done("ovf", d0);
    check("ovf_count", wq.size(), 3);
    check("ovf_b0", (wq.size() > 0) ? wq[0] : 8'h00, 8'hA5);
    check("ovf_b1", (wq.size() > 1) ? wq[1] : 8'h00, 8'h3C);
    check("ovf_b2", (wq.size() > 2) ? wq[2] : 8'h00, 8'hFF);
    check("ovf_status", last_status, 2'b11);

    // abort during byte 2
    clear_mon(); d0 = done_cnt;
    send_frame(1'b0, 2, 11, -1, -1, 4'hF);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    @(negedge clk);
    check("abt_busy", o_busy, 0);
    check("abt_status", o_status, 2'b11);
    for (int i = 0; i < 20; i++) strobe(4'h0, 1'b0);
    check("abt_writes", wq.size(), 1);
    check("abt_nodone", done_cnt - d0, 0);
    clear_mon(); d0 = done_cnt;
    send_frame(1'b0, 2, -1, -1, -1, 4'hF);
    wait_done("abt2", d0);
    verify_bytes("abt2", 4);
    check("abt2_status", last_status, 2'b00);

    // reset during byte 2
    clear_mon(); d0 = done_cnt;
    send_frame(1'b0, 2, 11, -1, -1, 4'hF);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    @(negedge clk);
    check("rsd_busy", o_busy, 0);
    for (int i = 0; i < 20; i++) strobe(4'h0, 1'b0);
    check("rsd_writes", wq.size(), 1);
    check("rsd_nodone", done_cnt - d0, 0);
    clear_mon(); d0 = done_cnt;
    send_frame(1'b0, 2, -1, -1, -1, 4'hF);
    wait_done("rsd2", d0);
    verify_bytes("rsd2", 4);
    check("rsd2_status", last_status, 2'b00);

    // start-bit timeout: 15 strobes with DAT held high
    clear_mon(); d0 = done_cnt;
    i_en = 1'b1; i_width = 1'b1; i_lgblk = 4'd2;
    @(negedge clk);
    check("to_busy_pre", o_busy, 0);
    tick();
    i_en = 1'b0;
    @(negedge clk);
    check("to_busy_rise", o_busy, 1);
    for (int i = 0; i < 14; i++) strobe(4'hF, 1'b0);
    @(negedge clk);
    check("to_early", done_cnt - d0, 0);
    check("to_busy_mid", o_busy, 1);
    strobe(4'hF, 1'b0);
    @(negedge clk);
    check("to_done", o_done, 1);
    check("to_status", o_status, 2'b10);
    check("to_busy_fall", o_busy, 0);
    tick(); tick();
    check("to_writes", wq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
